// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter.
// Holds the state encoding and the legal BRAM read-latency range.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RESP,
    ST_LOAD
  } arb_state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Data-memory BRAM port owner: CPU load/store vs UART loader.
// Stalls the single-cycle CPU across BRAM read latency and loader mode.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_rd_req,
  input  logic              cpu_wr_req,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              err_misalign,
  input  logic              ld_mode,
  input  logic              ld_wr_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT =
    (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
    (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = $clog2(LAT + 1);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic [ADDR_W-1:0] cpu_word;
  logic              cpu_mis;
  logic              idle_wr;
  logic              idle_rd;
  logic              ld_wr;
  logic              stall_c;
  logic              unused_addr_hi;

  assign cpu_word = cpu_addr[ADDR_W+1:2];
  assign cpu_mis  = |cpu_addr[1:0];
  assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

  // Store wins over load when both strobes are high.
  assign idle_wr = (state == ST_IDLE) && !ld_mode && cpu_wr_req;
  assign idle_rd = (state == ST_IDLE) && !ld_mode
                   && !cpu_wr_req && cpu_rd_req;
  assign ld_wr   = (state == ST_LOAD) && ld_wr_req;

  always_comb begin
    stall_c = 1'b0;
    unique case (1'b1)
      (state == ST_IDLE):    stall_c = ld_mode | idle_rd;
      (state == ST_RD_WAIT): stall_c = 1'b1;
      (state == ST_RESP):    stall_c = 1'b0;
      (state == ST_LOAD):    stall_c = 1'b1;
      default:               stall_c = 1'b0;
    endcase
  end

  assign cpu_stall = rst_n & stall_c;
  assign mem_en    = rst_n & (idle_wr | idle_rd | ld_wr);
  assign mem_we    = rst_n & (idle_wr | ld_wr);
  assign mem_addr  = (state == ST_LOAD) ? ld_addr : cpu_word;
  assign mem_wdata = (state == ST_LOAD) ? ld_wdata : cpu_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cpu_rdata    <= '0;
      err_misalign <= 1'b0;
      ld_ack       <= 1'b0;
    end else begin
      ld_ack <= ld_wr;
      if ((idle_wr | idle_rd) && cpu_mis)
        err_misalign <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ld_mode) begin
            state <= ST_LOAD;
          end else if (idle_rd) begin
            cnt   <= CNT_W'(LAT - 1);
            state <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cpu_rdata <= mem_rdata;
            state     <= ST_RESP;
          end
        end
        ST_RESP: state <= ld_mode ? ST_LOAD : ST_IDLE;
        ST_LOAD: if (!ld_mode) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
